rs232_frame_port: RTL and testbench
===================================

# rs232_frame_port

Parametrised RS-232 frame link with internal register RAM and a byte-lane output port. It receives 8N1 serial bytes and parses fixed-length frames (STX, CMD, data, pad, ETX). Write frames store a word in RAM; read frames send the word back on TX. After every accepted frame, one selectable byte lane of that frame's word is loaded onto an 8-bit port. It sits directly on the board UART pins and replaces the fixed 4-byte, fixed-lane receiver/transmitter pair.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (≥ 16).
- WORD_BYTES, 4: data bytes per frame and RAM word width in bytes (1..8).
- ADDR_W, 4: RAM address width; depth = 2^ADDR_W words (ADDR_W ≤ 7).
- SEL_W, 3: lane_sel width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- tx  out  1  serial output, idle high.
- lane_sel  in  SEL_W  byte lane loaded to port_out on frame accept.
- port_out  out  8  selected byte of the last accepted frame's word.
- frame_err  out  1  one-cycle pulse on any rejected byte or frame.
- busy  out  1  high while the parser is outside IDLE or TX is active or a response is pending.

## Operation
- RX front end:
  - 2-flop synchroniser on rx.
  - Start is detected on a falling edge and re-checked low at CLKS_PER_BIT/2.
  - Each data bit is sampled at mid-bit, LSB first; stop bit is sampled at mid-bit.
  - Stop bit = 0: byte discarded, frame_err pulsed, parser forced to IDLE.
- Frame format: 0x02, CMD, D0..D(WORD_BYTES-1), PAD, 0x03.
  - Word = {D(N-1)..D0}, with D0 in bits [7:0].
  - CMD[7] = 1 means write, 0 means read.
  - Address = CMD[ADDR_W-1:0]; CMD bits [6:ADDR_W] are ignored.
  - PAD value is ignored.
- Parser states:
  - IDLE: bytes other than 0x02 are ignored silently; 0x02 goes to CMD.
  - CMD: latch CMD; go to DATA.
  - DATA: count WORD_BYTES bytes. 0x02 inside DATA is plain data (no resync).
  - PAD: go to ETX.
  - ETX: 0x03 accepts the frame; any other value pulses frame_err and discards the frame. Both return to IDLE.
- On accept of a write frame: RAM[addr] <= word; lane source = received word.
- On accept of a read frame: lane source = RAM[addr]; a response is queued.
  - Response is 0x02, CMD echoed unchanged, the word D0 first, 0x00, 0x03.
- Lane load on every accept: port_out <= lane_sel < WORD_BYTES ? source[8*lane_sel +: 8] : 8'h00.
- Response queue is one-deep (pending register holding CMD and word).
  - If TX is idle, the response starts immediately.
  - If TX is busy, the response waits in pending.
  - If pending is already full, the new read is dropped with a frame_err pulse; RAM and port_out are still updated per the rules above.
- RAM contents are not reset. Reading an unwritten address returns undefined data.

## Timing
- Reset (rst low, asynchronous) sets:
  - tx=1, port_out=0, frame_err=0, busy=0.
  - Parser in IDLE, RX/TX shifters idle, pending empty.
- Reset mid-frame or mid-transmission aborts immediately; tx returns high the same cycle rst asserts.
- A byte is complete at the stop-bit sample cycle S. The parser acts at S+1.
- Accept occurs at ETX cycle S+1. At S+2:
  - RAM write is done.
  - port_out is updated.
  - A read-response start bit drives tx low, if TX was idle.
- TX timing:
  - Each bit lasts exactly CLKS_PER_BIT cycles; 1 stop bit.
  - Response bytes are back-to-back with no idle gap.
  - Pending launches the cycle after the previous stop bit ends.
- A write and a read to the same address in consecutive frames return the newly written word.
- frame_err is exactly 1 cycle wide per event. If two events occur in one cycle (impossible with a single RX), they coalesce.

## Test plan
- Write, then read back:
  - Stimulus: default params, CLKS_PER_BIT=16, lane_sel=0. Send 02,FF,04,08,16,32,00,03.
  - Expect: port_out=0x04 two cycles after ETX stop sample; RAM[0xF]=0x32160804.
  - Then send 02,7F,00,00,00,00,00,03.
  - Expect: tx emits 02,7F,04,08,16,32,00,03.
- Lane select and out-of-range:
  - Stimulus: with lane_sel=2, repeat the read of 0xF.
  - Expect: port_out=0x16.
  - Stimulus: with lane_sel=5, repeat it.
  - Expect: port_out=0x00.
- Bad ETX:
  - Stimulus: send 02,FE,0A,0B,0C,0D,00,07.
  - Expect: one frame_err pulse; RAM[0xE] unchanged; port_out unchanged; no TX activity.
- Framing error:
  - Stimulus: byte 0x55 sent with stop bit 0 during DATA.
  - Expect: frame_err pulse; parser back to IDLE.
  - Stimulus: then a following full valid write frame.
  - Expect: it is accepted.
- Back-to-back reads:
  - Stimulus: three read frames 02,7E..03 sent with no gaps.
  - Expect:
    - First read transmits.
    - Second read is pending and follows with no gap after the first response.
    - Third read gives frame_err only if it completes while pending is still full.
  - Check busy drops only after the last stop bit.
- Reset mid-transmission:
  - Stimulus: assert rst during byte 3 of a response.
  - Expect: tx=1, busy=0, port_out=0 immediately.
  - Stimulus: release rst, then send a valid write frame.
  - Expect: normal accept.

Source files
------------

// File: rtl/rs232_frame_port.sv
// RS-232 framed register port: 8N1 receiver, frame parser, word RAM,
// read-response transmitter with a one-deep queue, and a byte-lane output.
module rs232_frame_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4,
  parameter int ADDR_W       = 4,
  parameter int SEL_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic             tx,
  input  logic [SEL_W-1:0] lane_sel,
  output logic [7:0]       port_out,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int WORD_W   = 8 * WORD_BYTES;
  localparam int RSP_LAST = WORD_BYTES + 3;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [2:0] {P_IDLE, P_CMD, P_DATA, P_PAD, P_ETX} pState_t;

  logic             rxSync1_q, rxSync2_q, rxPrev_q;
  rxState_t         rxState_q, rxState_d;
  logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]       rxBitIdx_q, rxBitIdx_d;
  logic [7:0]       rxShift_q, rxShift_d;
  logic             rxValid_q, rxValid_d;
  logic [7:0]       rxByte_q, rxByte_d;
  logic             rxStopOk_q, rxStopOk_d;

  pState_t          pState_q, pState_d;
  logic [2:0]       byteCnt_q, byteCnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic             txActive_q, txActive_d;
  logic [3:0]       txIdx_q, txIdx_d;
  logic [3:0]       txBit_q, txBit_d;
  logic [CNT_W-1:0] txCnt_q, txCnt_d;
  logic             tx_q, tx_d;
  logic [7:0]       respCmd_q, respCmd_d;
  logic [WORD_W-1:0] respWord_q, respWord_d;
  logic             pendValid_q, pendValid_d;
  logic [7:0]       pendCmd_q, pendCmd_d;
  logic [WORD_W-1:0] pendWord_q, pendWord_d;

  logic [7:0]       portOut_q, portOut_d;
  logic             frameErr_q, frameErr_d;

  logic [WORD_W-1:0] mem [2**ADDR_W];

  logic              rxBad, byteOk, accept, etxBad, dropRead, txDone;
  logic              writeAccept, readAccept;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] ramRd, laneSrc;
  logic [31:0]       laneIdx;
  logic [7:0]        laneByte, txByte;
  logic              txBitVal;

  function automatic logic [7:0] respByte(input logic [3:0] idx, input logic [7:0] cmd,
                                          input logic [WORD_W-1:0] word);
    respByte = 8'h00;
    if (idx == 4'd0) respByte = 8'h02;
    else if (idx == 4'd1) respByte = cmd;
    else if (idx == 4'(RSP_LAST)) respByte = 8'h03;
    else begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (idx == 4'(i + 2)) respByte = word[8*i +: 8];
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
    end else begin
      rxSync1_q <= rx;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

  // Receiver: start qualified at half a bit, then every sample lands mid-bit.
  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    rxBitIdx_d = rxBitIdx_q;
    rxShift_d  = rxShift_q;
    rxValid_d  = 1'b0;
    rxByte_d   = rxByte_q;
    rxStopOk_d = rxStopOk_q;
    case (rxState_q)
      RX_IDLE: begin
        if (!rxSync2_q && rxPrev_q) begin
          rxState_d = RX_START;
          rxCnt_d   = '0;
        end
      end
      RX_START: begin
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d    = '0;
          rxBitIdx_d = 3'd0;
          rxState_d  = rxSync2_q ? RX_IDLE : RX_DATA;
        end else rxCnt_d = rxCnt_q + CNT_W'(1);
      end
      RX_DATA: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync2_q, rxShift_q[7:1]};
          if (rxBitIdx_q == 3'd7) rxState_d = RX_STOP;
          else rxBitIdx_d = rxBitIdx_q + 3'd1;
        end else rxCnt_d = rxCnt_q + CNT_W'(1);
      end
      RX_STOP: begin
        if (rxCnt_q == BIT_LAST) begin
          rxState_d  = RX_IDLE;
          rxValid_d  = 1'b1;
          rxByte_d   = rxShift_q;
          rxStopOk_d = rxSync2_q;
        end else rxCnt_d = rxCnt_q + CNT_W'(1);
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  assign rxBad  = rxValid_q && !rxStopOk_q;
  assign byteOk = rxValid_q && rxStopOk_q;

  always_comb begin
    pState_d  = pState_q;
    byteCnt_d = byteCnt_q;
    cmd_d     = cmd_q;
    word_d    = word_q;
    accept    = 1'b0;
    etxBad    = 1'b0;
    if (rxBad) pState_d = P_IDLE;
    else if (byteOk) begin
      case (pState_q)
        P_IDLE: if (rxByte_q == 8'h02) pState_d = P_CMD;
        P_CMD: begin
          cmd_d     = rxByte_q;
          byteCnt_d = 3'd0;
          pState_d  = P_DATA;
        end
        P_DATA: begin
          for (int i = 0; i < WORD_BYTES; i++)
            if (byteCnt_q == 3'(i)) word_d[8*i +: 8] = rxByte_q;
          if (byteCnt_q == 3'(WORD_BYTES - 1)) pState_d = P_PAD;
          else byteCnt_d = byteCnt_q + 3'd1;
        end
        P_PAD: pState_d = P_ETX;
        P_ETX: begin
          pState_d = P_IDLE;
          if (rxByte_q == 8'h03) accept = 1'b1;
          else etxBad = 1'b1;
        end
        default: pState_d = P_IDLE;
      endcase
    end
  end

  assign addr        = cmd_q[ADDR_W-1:0];
  assign ramRd       = mem[addr];
  assign writeAccept = accept && cmd_q[7];
  assign readAccept  = accept && !cmd_q[7];
  assign laneSrc     = cmd_q[7] ? word_q : ramRd;
  assign laneIdx     = 32'(lane_sel);

  always_comb begin
    laneByte = 8'h00;
    for (int i = 0; i < WORD_BYTES; i++)
      if (laneIdx == 32'(i)) laneByte = laneSrc[8*i +: 8];
  end

  // A read arriving exactly as the previous response finishes with nothing
  // pending starts straight away, so responses stay gapless.
  always_comb begin
    txActive_d  = txActive_q;
    txIdx_d     = txIdx_q;
    txBit_d     = txBit_q;
    txCnt_d     = txCnt_q;
    respCmd_d   = respCmd_q;
    respWord_d  = respWord_q;
    pendValid_d = pendValid_q;
    pendCmd_d   = pendCmd_q;
    pendWord_d  = pendWord_q;
    dropRead    = 1'b0;
    txDone      = 1'b0;
    if (txActive_q) begin
      if (txCnt_q == BIT_LAST) begin
        txCnt_d = '0;
        if (txBit_q == 4'd9) begin
          txBit_d = 4'd0;
          if (txIdx_q == 4'(RSP_LAST)) begin
            txDone  = 1'b1;
            txIdx_d = 4'd0;
            if (pendValid_q) begin
              respCmd_d   = pendCmd_q;
              respWord_d  = pendWord_q;
              pendValid_d = 1'b0;
            end else txActive_d = 1'b0;
          end else txIdx_d = txIdx_q + 4'd1;
        end else txBit_d = txBit_q + 4'd1;
      end else txCnt_d = txCnt_q + CNT_W'(1);
    end
    if (readAccept) begin
      if (!txActive_q || (txDone && !pendValid_q)) begin
        txActive_d = 1'b1;
        txIdx_d    = 4'd0;
        txBit_d    = 4'd0;
        txCnt_d    = '0;
        respCmd_d  = cmd_q;
        respWord_d = ramRd;
      end else if (!pendValid_q) begin
        pendValid_d = 1'b1;
        pendCmd_d   = cmd_q;
        pendWord_d  = ramRd;
      end else dropRead = 1'b1;
    end
    txByte   = respByte(txIdx_d, respCmd_d, respWord_d);
    txBitVal = 1'b1;
    if (txBit_d == 4'd0) txBitVal = 1'b0;
    for (int b = 0; b < 8; b++)
      if (txBit_d == 4'(b + 1)) txBitVal = txByte[b];
    tx_d = txActive_d ? txBitVal : 1'b1;
  end

  assign portOut_d  = accept ? laneByte : portOut_q;
  assign frameErr_d = rxBad || etxBad || dropRead;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxState_q   <= RX_IDLE;
      rxCnt_q     <= '0;
      rxBitIdx_q  <= 3'd0;
      rxShift_q   <= 8'h00;
      rxValid_q   <= 1'b0;
      rxByte_q    <= 8'h00;
      rxStopOk_q  <= 1'b0;
      pState_q    <= P_IDLE;
      byteCnt_q   <= 3'd0;
      cmd_q       <= 8'h00;
      word_q      <= '0;
      txActive_q  <= 1'b0;
      txIdx_q     <= 4'd0;
      txBit_q     <= 4'd0;
      txCnt_q     <= '0;
      tx_q        <= 1'b1;
      respCmd_q   <= 8'h00;
      respWord_q  <= '0;
      pendValid_q <= 1'b0;
      pendCmd_q   <= 8'h00;
      pendWord_q  <= '0;
      portOut_q   <= 8'h00;
      frameErr_q  <= 1'b0;
    end else begin
      rxState_q   <= rxState_d;
      rxCnt_q     <= rxCnt_d;
      rxBitIdx_q  <= rxBitIdx_d;
      rxShift_q   <= rxShift_d;
      rxValid_q   <= rxValid_d;
      rxByte_q    <= rxByte_d;
      rxStopOk_q  <= rxStopOk_d;
      pState_q    <= pState_d;
      byteCnt_q   <= byteCnt_d;
      cmd_q       <= cmd_d;
      word_q      <= word_d;
      txActive_q  <= txActive_d;
      txIdx_q     <= txIdx_d;
      txBit_q     <= txBit_d;
      txCnt_q     <= txCnt_d;
      tx_q        <= tx_d;
      respCmd_q   <= respCmd_d;
      respWord_q  <= respWord_d;
      pendValid_q <= pendValid_d;
      pendCmd_q   <= pendCmd_d;
      pendWord_q  <= pendWord_d;
      portOut_q   <= portOut_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // Register RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (writeAccept) mem[addr] <= word_q;
  end

  assign tx        = tx_q;
  assign port_out  = portOut_q;
  assign frame_err = frameErr_q;
  assign busy      = (pState_q != P_IDLE) || txActive_q || pendValid_q;

endmodule

// File: tb/tb_rs232_frame_port.sv
// Directed bench for rs232_frame_port: drives 8N1 frames on rx, decodes tx,
// and compares port/response/error behaviour against hand-computed values.
module tb_rs232_frame_port;

  localparam int CPB      = 16;
  localparam int WB       = 4;
  localparam int AW       = 4;
  localparam int SW       = 3;
  localparam int BYTE_CYC = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [SW-1:0] laneSel;
  logic          tx;
  logic [7:0]    portOut;
  logic          frameErr;
  logic          busy;

  int          checksRun = 0;
  int          checksPassed = 0;
  int unsigned cyc = 0;
  int          errPulses = 0;
  int          errHigh = 0;
  logic        errPrev = 1'b0;
  logic        busyPrev = 1'b0;
  int unsigned busyFallCyc = 0;
  int          errBase;
  int          highBase;
  int unsigned frameEnd;

  logic [7:0]  txBytes[$];
  int unsigned txStarts[$];
  logic        txStops[$];

  rs232_frame_port #(
    .CLKS_PER_BIT(CPB),
    .WORD_BYTES(WB),
    .ADDR_W(AW),
    .SEL_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .tx(tx),
    .lane_sel(laneSel),
    .port_out(portOut),
    .frame_err(frameErr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    errPrev  <= frameErr;
    busyPrev <= busy;
    if (frameErr === 1'b1) errHigh <= errHigh + 1;
    if (frameErr === 1'b1 && errPrev !== 1'b1) errPulses <= errPulses + 1;
    if (busyPrev === 1'b1 && busy === 1'b0) busyFallCyc <= cyc;
  end

  initial begin
    int unsigned st;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        txStops.push_back(tx);
        txBytes.push_back(b);
        txStarts.push_back(st);
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checksRun++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic alignEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] value, input logic stopBit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = value[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stopBit;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [8*WB-1:0] word,
                               input logic [7:0] etx);
    sendByte(8'h02, 1'b1);
    sendByte(cmd, 1'b1);
    for (int i = 0; i < WB; i++) sendByte(word[8*i +: 8], 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(etx, 1'b1);
    frameEnd = cyc;
  endtask

  task automatic waitTxBytes(input int n, input string tag);
    int budget = 4000;
    while (txBytes.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (txBytes.size() < n) checkOutput(tag, 64'(txBytes.size()), 64'(n));
  endtask

  task automatic waitIdle(input string tag);
    int budget = 500;
    while (busy !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (busy !== 1'b0) checkOutput(tag, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic clearTx();
    txBytes.delete();
    txStarts.delete();
    txStops.delete();
  endtask

  task automatic checkResponse(input string tag, input int base, input logic [7:0] cmd,
                               input logic [31:0] word);
    logic [63:0] expect64;
    logic [63:0] obs;
    logic [7:0]  stops;
    expect64 = {8'h03, 8'h00, word, cmd, 8'h02};
    obs = '0;
    stops = '0;
    for (int k = 0; k < 8; k++) begin
      if (base + k < txBytes.size()) begin
        obs[8*k +: 8] = txBytes[base + k];
        stops[k] = txStops[base + k];
      end
    end
    checkOutput({tag, "_bytes"}, obs, expect64);
    checkOutput({tag, "_stops"}, 64'(stops), 64'hFF);
  endtask

  task automatic checkGaps(input string tag, input int n);
    int ok = 0;
    for (int k = 1; k < n; k++)
      if (k < txStarts.size() && txStarts[k] - txStarts[k-1] == BYTE_CYC) ok++;
    checkOutput(tag, 64'(ok), 64'(n - 1));
  endtask

  initial begin
    rx = 1'b1;
    laneSel = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", 64'(tx), 64'd1);
    checkOutput("reset_port", 64'(portOut), 64'd0);
    checkOutput("reset_ferr", 64'(frameErr), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    alignEdge();

    // Write 0x32160804 to address 0xF, lane 0
    applyStimulus(8'hFF, 32'h3216_0804, 8'h03);
    repeat (2) @(negedge clk);
    checkOutput("wr_port", 64'(portOut), 64'h04);
    checkOutput("wr_busy", 64'(busy), 64'd0);
    checkOutput("wr_noerr", 64'(errPulses), 64'd0);
    checkOutput("wr_notx", 64'(txBytes.size()), 64'd0);

    // Read it back
    alignEdge();
    applyStimulus(8'h7F, 32'h0, 8'h03);
    waitTxBytes(8, "rdF_timeout");
    checkResponse("rdF", 0, 8'h7F, 32'h3216_0804);
    checkOutput("rdF_start", 64'(txStarts.size() > 0 && txStarts[0] <= frameEnd
                                 && frameEnd - txStarts[0] <= 8), 64'd1);
    checkOutput("rdF_port", 64'(portOut), 64'h04);
    waitIdle("rdF_idle");
    clearTx();

    // Lane 2, then an out-of-range lane
    laneSel = 3'd2;
    alignEdge();
    applyStimulus(8'h7F, 32'h0, 8'h03);
    repeat (2) @(negedge clk);
    checkOutput("lane2_port", 64'(portOut), 64'h16);
    waitTxBytes(8, "lane2_timeout");
    checkResponse("lane2", 0, 8'h7F, 32'h3216_0804);
    waitIdle("lane2_idle");
    clearTx();
    laneSel = 3'd5;
    alignEdge();
    applyStimulus(8'h7F, 32'h0, 8'h03);
    repeat (2) @(negedge clk);
    checkOutput("lane5_port", 64'(portOut), 64'h00);
    waitTxBytes(8, "lane5_timeout");
    waitIdle("lane5_idle");
    clearTx();

    // Bad ETX must not disturb RAM, port or TX
    laneSel = 3'd0;
    alignEdge();
    applyStimulus(8'hFE, 32'hAABB_CCDD, 8'h03);
    repeat (2) @(negedge clk);
    checkOutput("wrE_port", 64'(portOut), 64'hDD);
    errBase = errPulses;
    highBase = errHigh;
    alignEdge();
    applyStimulus(8'hFE, 32'h0D0C_0B0A, 8'h07);
    repeat (20) @(negedge clk);
    checkOutput("badetx_pulses", 64'(errPulses - errBase), 64'd1);
    checkOutput("badetx_width", 64'(errHigh - highBase), 64'd1);
    checkOutput("badetx_port", 64'(portOut), 64'hDD);
    checkOutput("badetx_notx", 64'(txBytes.size()), 64'd0);
    alignEdge();
    applyStimulus(8'h7E, 32'h0, 8'h03);
    waitTxBytes(8, "rdE_timeout");
    checkResponse("rdE", 0, 8'h7E, 32'hAABB_CCDD);
    waitIdle("rdE_idle");
    clearTx();

    // Stop-bit error in the middle of DATA
    errBase = errPulses;
    alignEdge();
    sendByte(8'h02, 1'b1);
    sendByte(8'hFD, 1'b1);
    sendByte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("ferr_pulse", 64'(errPulses - errBase), 64'd1);
    checkOutput("ferr_idle", 64'(busy), 64'd0);
    errBase = errPulses;
    alignEdge();
    applyStimulus(8'hFD, 32'h1122_3344, 8'h03);
    repeat (2) @(negedge clk);
    checkOutput("ferr_wr_port", 64'(portOut), 64'h44);
    checkOutput("ferr_wr_noerr", 64'(errPulses - errBase), 64'd0);
    alignEdge();
    applyStimulus(8'h7D, 32'h0, 8'h03);
    waitTxBytes(8, "rdD_timeout");
    checkResponse("rdD", 0, 8'h7D, 32'h1122_3344);
    waitIdle("rdD_idle");
    clearTx();

    // Three reads with no gap between frames
    errBase = errPulses;
    alignEdge();
    for (int f = 0; f < 3; f++) applyStimulus(8'h7E, 32'h0, 8'h03);
    waitTxBytes(24, "b2b_timeout");
    checkResponse("b2b0", 0, 8'h7E, 32'hAABB_CCDD);
    checkResponse("b2b1", 8, 8'h7E, 32'hAABB_CCDD);
    checkResponse("b2b2", 16, 8'h7E, 32'hAABB_CCDD);
    checkGaps("b2b_gaps", 24);
    waitIdle("b2b_idle");
    checkOutput("b2b_noerr", 64'(errPulses - errBase), 64'd0);
    checkOutput("b2b_busyfall", 64'(txStarts.size() == 24 ? busyFallCyc - txStarts[23] : 0),
                64'(BYTE_CYC));
    clearTx();

    // Reset during the third response byte
    alignEdge();
    applyStimulus(8'h7F, 32'h0, 8'h03);
    waitTxBytes(2, "rst_rd_timeout");
    repeat (60) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_tx", 64'(tx), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_port", 64'(portOut), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (250) @(negedge clk);
    clearTx();
    errBase = errPulses;
    laneSel = 3'd3;
    alignEdge();
    applyStimulus(8'h83, 32'hCAFE_F00D, 8'h03);
    repeat (2) @(negedge clk);
    checkOutput("post_rst_port", 64'(portOut), 64'hCA);
    checkOutput("post_rst_notx", 64'(txBytes.size()), 64'd0);
    alignEdge();
    applyStimulus(8'h03, 32'h0, 8'h03);
    waitTxBytes(8, "post_rst_timeout");
    checkResponse("post_rst_rd", 0, 8'h03, 32'hCAFE_F00D);
    waitIdle("post_rst_idle");
    checkOutput("post_rst_noerr", 64'(errPulses - errBase), 64'd0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
